// File: rtl/mvm_pkg.sv
// Shared scheduler state encoding and default engine geometry for the MVM tile scheduler.
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUT
    } state_t;

    localparam int DEF_ACT_BITS  = 8;
    localparam int DEF_MAT_BITS  = 8;
    localparam int DEF_MAT_H     = 3;
    localparam int DEF_MAT_W     = 3;
    localparam int DEF_MAX_TILES = 16;

endpackage

// File: rtl/mvm_accum.sv
// Per-column signed accumulators folding engine partial sums across row tiles.
module mvm_accum
    import mvm_pkg::*;
#(
    parameter int matW    = DEF_MAT_W,
    parameter int outBits = 18,
    parameter int accBits = 23
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     valid_i,
    input  logic                     first_i,
    input  logic [matW*outBits-1:0]  y_i,
    output logic [matW*accBits-1:0]  acc_o
);

    function automatic logic signed [accBits-1:0] sext(input logic signed [outBits-1:0] v);
        return accBits'(v);
    endfunction

    for (genvar j = 0; j < matW; j++) begin : g_col
        logic signed [outBits-1:0] y_p1;
        logic signed [accBits-1:0] acc_p2;

        assign y_p1 = y_i[j*outBits +: outBits];

        // p1 -> p2: the first row tile restarts the sum, later tiles add to it
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                acc_p2 <= '0;
            end else if (valid_i) begin
                acc_p2 <= first_i ? sext(y_p1) : acc_p2 + sext(y_p1);
            end
        end

        assign acc_o[j*accBits +: accBits] = acc_p2;
    end

endmodule

// File: rtl/mvm_sched.sv
// Tile scheduler: issues R row-tile reads per column tile, accumulates engine results
// returned two cycles later, and hands each column-tile sum to the consumer.
module mvm_sched
    import mvm_pkg::*;
#(
    parameter int activationBits = DEF_ACT_BITS,
    parameter int matBits        = DEF_MAT_BITS,
    parameter int matH           = DEF_MAT_H,
    parameter int matW           = DEF_MAT_W,
    parameter int maxTiles       = DEF_MAX_TILES,
    localparam int tileBits      = $clog2(maxTiles) + 1,
    localparam int outBits       = activationBits + matBits + $clog2(matH),
    localparam int accBits       = outBits + tileBits
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [tileBits-1:0]      cfg_row_tiles_i,
    input  logic [tileBits-1:0]      cfg_col_tiles_i,
    output logic                     rd_en_o,
    output logic [tileBits-1:0]      act_addr_o,
    output logic [2*tileBits-1:0]    w_addr_o,
    input  logic [matW*outBits-1:0]  eng_y_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [matW*accBits-1:0]  out_data_o,
    output logic [tileBits-1:0]      out_col_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [tileBits-1:0]   TILE_ONE  = tileBits'(1);
    localparam logic [2*tileBits-1:0] WADDR_ONE = (2*tileBits)'(1);

    state_t                  state, next_state;
    logic [tileBits-1:0]     row_tiles, col_tiles, row_cnt, col_cnt;
    logic [2*tileBits-1:0]   w_cnt;
    logic                    vld_p0, first_p0, last_p0;
    logic                    vld_p1, first_p1, last_p1;
    logic                    done_q;
    logic                    issue_last, col_last, cfg_empty, cfg_hs, out_hs;

    assign issue_last = (row_cnt == row_tiles - TILE_ONE);
    assign col_last   = (col_cnt == col_tiles - TILE_ONE);
    assign cfg_empty  = (cfg_row_tiles_i == '0) || (cfg_col_tiles_i == '0);
    assign cfg_hs     = cfg_valid_i && cfg_ready_o;
    assign out_hs     = out_valid_o && out_ready_i;

    always_comb begin
        next_state  = state;
        cfg_ready_o = 1'b0;
        rd_en_o     = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i && !cfg_empty) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                rd_en_o = 1'b1;
                if (issue_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vld_p1 && last_p1) next_state = ST_OUT;
            end
            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) next_state = col_last ? ST_IDLE : ST_ISSUE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // issue -> p0 (buffer data) -> p1 (engine result); flags ride with the read strobe
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            row_tiles <= '0;
            col_tiles <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            w_cnt     <= '0;
            done_q    <= 1'b0;
            vld_p0    <= 1'b0;
            first_p0  <= 1'b0;
            last_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            state    <= next_state;
            done_q   <= (cfg_hs && cfg_empty) || (out_hs && col_last);
            vld_p0   <= rd_en_o;
            first_p0 <= rd_en_o && (row_cnt == '0);
            last_p0  <= rd_en_o && issue_last;
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
            if (cfg_hs) begin
                row_tiles <= cfg_row_tiles_i;
                col_tiles <= cfg_col_tiles_i;
                row_cnt   <= '0;
                col_cnt   <= '0;
                w_cnt     <= '0;
            end
            // weight index runs on across column tiles, giving c*R+r without a multiply
            if (rd_en_o) begin
                w_cnt   <= w_cnt + WADDR_ONE;
                row_cnt <= issue_last ? '0 : row_cnt + TILE_ONE;
            end
            if (out_hs && !col_last) col_cnt <= col_cnt + TILE_ONE;
        end
    end

    mvm_accum #(
        .matW    (matW),
        .outBits (outBits),
        .accBits (accBits)
    ) u_accum (
        .clk     (clk),
        .nrst    (nrst),
        .valid_i (vld_p1),
        .first_i (first_p1),
        .y_i     (eng_y_i),
        .acc_o   (out_data_o)
    );

    assign act_addr_o = row_cnt;
    assign w_addr_o   = w_cnt;
    assign out_col_o  = col_cnt;
    assign busy_o     = (state != ST_IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_mvm_sched.sv
// Randomized bench for mvm_sched: the bench plays buffer+engine and predicts every
// cycle of each job from its row/column tile counts.
module tb_mvm_sched;

    localparam int MW  = 3;
    localparam int OB  = 18;
    localparam int AB  = 23;
    localparam int TBW = 5;

    logic              clk = 1'b0;
    logic              nrst;
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic [TBW-1:0]    cfg_row_tiles_i;
    logic [TBW-1:0]    cfg_col_tiles_i;
    logic              rd_en_o;
    logic [TBW-1:0]    act_addr_o;
    logic [2*TBW-1:0]  w_addr_o;
    logic [MW*OB-1:0]  eng_y_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [MW*AB-1:0]  out_data_o;
    logic [TBW-1:0]    out_col_o;
    logic              busy_o;
    logic              done_o;

    mvm_sched dut (
        .clk             (clk),
        .nrst            (nrst),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_row_tiles_i (cfg_row_tiles_i),
        .cfg_col_tiles_i (cfg_col_tiles_i),
        .rd_en_o         (rd_en_o),
        .act_addr_o      (act_addr_o),
        .w_addr_o        (w_addr_o),
        .eng_y_i         (eng_y_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_col_o       (out_col_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    int               total;
    int               bad;
    int               cyc;
    bit               early;
    int               due_q[$];
    logic [MW*OB-1:0] yv_q[$];
    logic [MW*OB-1:0] dir_q[$];
    longint           exp_sum[MW];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [MW*OB-1:0] mk_y(input int a, input int b, input int c);
        logic [MW*OB-1:0] v;
        int t[MW];
        int x;
        t = '{a, b, c};
        for (int j = 0; j < MW; j++) begin
            x = t[j];
            v[j*OB +: OB] = x[OB-1:0];
        end
        return v;
    endfunction

    function automatic logic [MW*OB-1:0] rand_y();
        int x[MW];
        for (int j = 0; j < MW; j++) x[j] = int'($urandom_range(0, 262143)) - 131072;
        return mk_y(x[0], x[1], x[2]);
    endfunction

    function automatic logic [MW*AB-1:0] exp_vec();
        logic [MW*AB-1:0] r;
        longint s;
        for (int j = 0; j < MW; j++) begin
            s = exp_sum[j];
            r[j*AB +: AB] = s[AB-1:0];
        end
        return r;
    endfunction

    // one cycle: engine result for a read two cycles back, otherwise junk on eng_y_i
    task automatic tick();
        logic [MW*OB-1:0] v;
        @(negedge clk);
        cyc++;
        out_ready_i = early;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            eng_y_i = yv_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            eng_y_i = rand_y();
        end
        if (rd_en_o) begin
            if (dir_q.size() > 0) v = dir_q.pop_front();
            else v = rand_y();
            due_q.push_back(cyc + 2);
            yv_q.push_back(v);
            for (int j = 0; j < MW; j++) exp_sum[j] += $signed(v[j*OB +: OB]);
        end
    endtask

    task automatic run_job(input int rows, input int cols, input int hold_in, input bit erly);
        int hold;
        hold  = erly ? 0 : hold_in;
        early = erly;
        chk("cfg_ready_idle", 96'(cfg_ready_o), 96'(1));
        cfg_valid_i     = 1'b1;
        cfg_row_tiles_i = rows[TBW-1:0];
        cfg_col_tiles_i = cols[TBW-1:0];
        @(posedge clk);
        #1;
        cfg_valid_i     = 1'b0;
        cfg_row_tiles_i = TBW'($urandom);
        cfg_col_tiles_i = TBW'($urandom);
        if (rows == 0 || cols == 0) begin
            tick();
            chk("empty_done", 96'(done_o), 96'(1));
            chk("empty_rd", 96'(rd_en_o), 96'(0));
            chk("empty_busy", 96'(busy_o), 96'(0));
            chk("empty_cfg_ready", 96'(cfg_ready_o), 96'(1));
            repeat (3) begin
                tick();
                chk("empty_done_after", 96'(done_o), 96'(0));
                chk("empty_rd_after", 96'(rd_en_o), 96'(0));
                chk("empty_out_valid", 96'(out_valid_o), 96'(0));
            end
            return;
        end
        for (int t = 0; t < cols; t++) begin
            for (int j = 0; j < MW; j++) exp_sum[j] = 0;
            for (int i = 0; i < rows; i++) begin
                tick();
                chk("issue_rd", 96'(rd_en_o), 96'(1));
                chk("issue_act_addr", 96'(act_addr_o), 96'(i));
                chk("issue_w_addr", 96'(w_addr_o), 96'(t * rows + i));
                chk("issue_out_valid", 96'(out_valid_o), 96'(0));
                chk("issue_cfg_ready", 96'(cfg_ready_o), 96'(0));
                chk("issue_busy", 96'(busy_o), 96'(1));
                chk("issue_done", 96'(done_o), 96'(0));
            end
            repeat (2) begin
                tick();
                chk("drain_rd", 96'(rd_en_o), 96'(0));
                chk("drain_out_valid", 96'(out_valid_o), 96'(0));
                chk("drain_cfg_ready", 96'(cfg_ready_o), 96'(0));
            end
            for (int h = 0; h <= hold; h++) begin
                tick();
                chk("out_valid", 96'(out_valid_o), 96'(1));
                chk("out_data", 96'(out_data_o), 96'(exp_vec()));
                chk("out_col", 96'(out_col_o), 96'(t));
                chk("out_rd", 96'(rd_en_o), 96'(0));
                chk("out_cfg_ready", 96'(cfg_ready_o), 96'(0));
                chk("out_busy", 96'(busy_o), 96'(1));
            end
            out_ready_i = 1'b1;
        end
        tick();
        chk("end_done", 96'(done_o), 96'(1));
        chk("end_busy", 96'(busy_o), 96'(0));
        chk("end_cfg_ready", 96'(cfg_ready_o), 96'(1));
        chk("end_out_valid", 96'(out_valid_o), 96'(0));
        tick();
        chk("end_done_pulse", 96'(done_o), 96'(0));
    endtask

    task automatic reset_mid();
        early = 1'b0;
        chk("rst_cfg_ready_pre", 96'(cfg_ready_o), 96'(1));
        cfg_valid_i     = 1'b1;
        cfg_row_tiles_i = 5'd4;
        cfg_col_tiles_i = 5'd1;
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_pre_rd", 96'(rd_en_o), 96'(1));
        #2 nrst = 1'b0;
        #1;
        chk("rst_rd", 96'(rd_en_o), 96'(0));
        chk("rst_busy", 96'(busy_o), 96'(0));
        chk("rst_out_valid", 96'(out_valid_o), 96'(0));
        chk("rst_done", 96'(done_o), 96'(0));
        chk("rst_act_addr", 96'(act_addr_o), 96'(0));
        chk("rst_w_addr", 96'(w_addr_o), 96'(0));
        chk("rst_out_data", 96'(out_data_o), 96'(0));
        chk("rst_out_col", 96'(out_col_o), 96'(0));
        due_q.delete();
        yv_q.delete();
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        chk("rst_cfg_ready_post", 96'(cfg_ready_o), 96'(1));
        repeat (5) begin
            tick();
            chk("rst_no_out_valid", 96'(out_valid_o), 96'(0));
            chk("rst_no_done", 96'(done_o), 96'(0));
            chk("rst_no_rd", 96'(rd_en_o), 96'(0));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        early = 1'b0;
        nrst = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_row_tiles_i = '0;
        cfg_col_tiles_i = '0;
        out_ready_i = 1'b0;
        eng_y_i = '0;
        for (int j = 0; j < MW; j++) exp_sum[j] = 0;
        repeat (2) @(negedge clk);
        chk("init_rd", 96'(rd_en_o), 96'(0));
        chk("init_busy", 96'(busy_o), 96'(0));
        chk("init_out_valid", 96'(out_valid_o), 96'(0));
        chk("init_done", 96'(done_o), 96'(0));
        chk("init_out_data", 96'(out_data_o), 96'(0));
        nrst = 1'b1;
        tick();
        chk("init_cfg_ready", 96'(cfg_ready_o), 96'(1));

        dir_q.push_back(mk_y(5, 6, 7));
        run_job(1, 1, 0, 1'b0);
        repeat (6) dir_q.push_back(mk_y(1, 2, 3));
        run_job(3, 2, 1, 1'b0);
        dir_q.push_back(mk_y(-4, 0, 100));
        dir_q.push_back(mk_y(1, 1, -200));
        run_job(2, 1, 0, 1'b0);
        run_job(2, 1, 10, 1'b0);
        run_job(0, 4, 0, 1'b0);
        run_job(3, 0, 0, 1'b0);
        run_job(2, 2, 0, 1'b1);
        reset_mid();
        run_job(3, 2, 2, 1'b0);

        for (int n = 0; n < 10; n++) begin
            run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
